// File: rtl/cpu_ri_multicycle.sv
// Multicycle MIPS R/I-subset core: FETCH -> DECODE -> EXECUTE -> WRITEBACK per instruction,
// with a combinational register observation port and a sticky illegal-instruction flag.
module cpu_ri_multicycle #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int RET_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    input  logic              halt_i,
    input  logic [4:0]        obs_sel,
    output logic [DATA_W-1:0] obs_data,
    output logic [PC_W-1:0]   pc_o,
    output logic [2:0]        state_o,
    output logic              illegal_o,
    output logic [RET_W-1:0]  retired_o
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALTED    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d, alu_q, alu_d;
    logic              illegal_q, illegal_d;
    logic [RET_W-1:0]  ret_q, ret_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] rf_q [32];

    logic [5:0]         op_s, funct_s;
    logic [4:0]         rs_s, rt_s, rd_s, shamt_s, dest_s;
    logic               legal_s, rf_we_s;
    logic [DATA_W-1:0]  imm_s, alu_s;
    logic [DATA_W+15:0] lui_wide_s;

    assign op_s    = ir_q[31:26];
    assign rs_s    = ir_q[25:21];
    assign rt_s    = ir_q[20:16];
    assign rd_s    = ir_q[15:11];
    assign shamt_s = ir_q[10:6];
    assign funct_s = ir_q[5:0];

    // Instruction legality and destination register selection
    always_comb begin
        legal_s = 1'b0;
        dest_s  = 5'd0;
        case (op_s)
            6'h00: begin
                dest_s = rd_s;
                case (funct_s)
                    6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A: legal_s = 1'b1;
                    default: legal_s = 1'b0;
                endcase
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                legal_s = 1'b1;
                dest_s  = rt_s;
            end
            default: begin
                legal_s = 1'b0;
                dest_s  = 5'd0;
            end
        endcase
    end

    // Immediate formation: sign-extend for arithmetic/compare, zero-extend for logic, shift for lui
    always_comb begin
        lui_wide_s = {{DATA_W{1'b0}}, ir_q[15:0]} << 5'd16;
        case (op_s)
            6'h08, 6'h0A:        imm_s = DATA_W'($signed(ir_q[15:0]));
            6'h0C, 6'h0D, 6'h0E: imm_s = DATA_W'(ir_q[15:0]);
            6'h0F:               imm_s = lui_wide_s[DATA_W-1:0];
            default:             imm_s = '0;
        endcase
    end

    // ALU result from the latched operands
    always_comb begin
        alu_s = '0;
        if (op_s == 6'h00) begin
            case (funct_s)
                6'h20:   alu_s = a_q + b_q;
                6'h22:   alu_s = a_q - b_q;
                6'h24:   alu_s = a_q & b_q;
                6'h25:   alu_s = a_q | b_q;
                6'h26:   alu_s = a_q ^ b_q;
                6'h27:   alu_s = ~(a_q | b_q);
                6'h2A:   alu_s = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1'b1) : '0;
                6'h00:   alu_s = b_q << shamt_s;
                default: alu_s = '0;
            endcase
        end else begin
            case (op_s)
                6'h08:   alu_s = a_q + imm_q;
                6'h0A:   alu_s = ($signed(a_q) < $signed(imm_q)) ? DATA_W'(1'b1) : '0;
                6'h0C:   alu_s = a_q & imm_q;
                6'h0D:   alu_s = a_q | imm_q;
                6'h0E:   alu_s = a_q ^ imm_q;
                6'h0F:   alu_s = imm_q;
                default: alu_s = '0;
            endcase
        end
    end

    // Sequencing and next-state of all architectural and pipeline registers
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        illegal_d = illegal_q;
        ret_d     = ret_q;
        rf_we_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt_i) state_d = HALTED;
                else        state_d = FETCH;
            end
            FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                a_d     = rf_q[rs_s];
                b_d     = rf_q[rt_s];
                imm_d   = imm_s;
                state_d = EXECUTE;
            end
            EXECUTE: begin
                alu_d   = alu_s;
                state_d = WRITEBACK;
            end
            WRITEBACK: begin
                rf_we_s = legal_s && (dest_s != 5'd0);
                if (legal_s) illegal_d = illegal_q;
                else         illegal_d = 1'b1;
                pc_d  = pc_q + PC_W'(1'b1);
                ret_d = ret_q + RET_W'(1'b1);
                if (halt_i) state_d = HALTED;
                else        state_d = FETCH;
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
        req_d = (state_d == FETCH);
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            ir_q      <= 32'h0000_0000;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            alu_q     <= '0;
            illegal_q <= 1'b0;
            ret_q     <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            imm_q     <= imm_d;
            alu_q     <= alu_d;
            illegal_q <= illegal_d;
            ret_q     <= ret_d;
            req_q     <= req_d;
        end
    end

    // Register file; entry 0 is never written so it reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (rf_we_s) begin
            rf_q[dest_s] <= alu_q;
        end
    end

    assign obs_data  = (obs_sel == 5'd0) ? '0 : rf_q[obs_sel];
    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc_o      = pc_q;
    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign retired_o = ret_q;

endmodule

// File: tb/tb_cpu_ri_multicycle.sv
// Bench for cpu_ri_multicycle: directed scenarios plus random instruction streams, each
// checked against an instruction-level model of the R/I subset.
module tb_cpu_ri_multicycle;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        halt_i = 1'b0;
    logic [4:0]  obs_sel = 5'd0;
    logic [31:0] obs_data;
    logic [7:0]  pc_o;
    logic [2:0]  state_o;
    logic        illegal_o;
    logic [15:0] retired_o;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0;
    logic chk_en = 1'b0;

    logic [31:0] m_rf [32];
    logic [7:0]  m_pc;
    logic [15:0] m_ret;
    logic        m_ill;
    logic [2:0]  exp_state;
    logic        exp_req;

    cpu_ri_multicycle dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .halt_i(halt_i),
        .obs_sel(obs_sel), .obs_data(obs_data), .pc_o(pc_o), .state_o(state_o),
        .illegal_o(illegal_o), .retired_o(retired_o)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [5:0]  code;
        int k;
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
        imm = 16'($urandom);
        k = int'($urandom_range(0, 15));
        case (k)
            0: code = 6'h20;  1: code = 6'h22;  2: code = 6'h24;  3: code = 6'h25;
            4: code = 6'h26;  5: code = 6'h27;  6: code = 6'h2A;  7: code = 6'h00;
            8: code = 6'h08;  9: code = 6'h0A; 10: code = 6'h0C; 11: code = 6'h0D;
            12: code = 6'h0E; 13: code = 6'h0F; 14: code = 6'h23;
            default: code = 6'h21;
        endcase
        if (k < 8 || k == 15) return r_type(rs, rt, rd, sh, code);
        return i_type(code, rs, rt, imm);
    endfunction

    // Architectural effect of one retired instruction
    task automatic model_exec(input logic [31:0] w);
        logic [5:0]  op, fn;
        logic [4:0]  d;
        logic [31:0] a, b, se, ze, r;
        logic        ok;
        op = w[31:26]; fn = w[5:0];
        a = m_rf[w[25:21]]; b = m_rf[w[20:16]];
        se = {{16{w[15]}}, w[15:0]};
        ze = {16'h0000, w[15:0]};
        ok = 1'b1; d = w[20:16]; r = 32'h0;
        if (op == 6'h00) begin
            d = w[15:11];
            case (fn)
                6'h20: r = a + b;
                6'h22: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h00: r = b << w[10:6];
                default: ok = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: r = a + se;
                6'h0A: r = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
                6'h0C: r = a & ze;
                6'h0D: r = a | ze;
                6'h0E: r = a ^ ze;
                6'h0F: r = {w[15:0], 16'h0000};
                default: ok = 1'b0;
            endcase
        end
        if (ok && d != 5'd0) m_rf[d] = r;
        if (!ok) m_ill = 1'b1;
        m_pc = m_pc + 8'd1;
        m_ret = m_ret + 16'd1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_pc = 8'd0; m_ret = 16'd0; m_ill = 1'b0;
        exp_state = 3'd0; exp_req = 1'b0;
    endtask

    task automatic sweep();
        for (int i = 0; i < 32; i++) begin
            obs_sel = 5'(i);
            #1;
            chk($sformatf("obs_r%0d", i), 64'(obs_data), 64'(m_rf[i]));
        end
    endtask

    // Called just after an edge with the core in FETCH; returns just after the WRITEBACK edge
    task automatic do_instr(input logic [31:0] w, input int nwait, input logic hlt);
        for (int i = 0; i < nwait; i++) begin
            imem_valid = 1'b0; imem_rdata = $urandom; halt_i = 1'($urandom);
            @(posedge clk); #1;
        end
        imem_valid = 1'b1; imem_rdata = w;
        @(posedge clk); #1;
        exp_state = 3'd2; exp_req = 1'b0;
        imem_valid = 1'($urandom); imem_rdata = $urandom; halt_i = 1'($urandom);
        @(posedge clk); #1;
        exp_state = 3'd3;
        imem_valid = 1'($urandom); imem_rdata = $urandom; halt_i = 1'($urandom);
        @(posedge clk); #1;
        exp_state = 3'd4; halt_i = hlt;
        @(posedge clk); #1;
        model_exec(w);
        exp_state = hlt ? 3'd5 : 3'd1; exp_req = !hlt; halt_i = 1'b0;
        sweep();
    endtask

    // Per-cycle comparison of the visible core status against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state_o", 64'(state_o), 64'(exp_state));
            chk("imem_req", 64'(imem_req), 64'(exp_req));
            chk("pc_o", 64'(pc_o), 64'(m_pc));
            chk("imem_addr", 64'(imem_addr), 64'(m_pc));
            chk("retired_o", 64'(retired_o), 64'(m_ret));
            chk("illegal_o", 64'(illegal_o), 64'(m_ill));
        end
    end

    initial begin
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sweep();
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_state = 3'd1; exp_req = 1'b1; t0 = cyc;

        // addi/addi/add with no fetch stalls
        do_instr(i_type(6'h08, 5'd0, 5'd1, 16'd5), 0, 1'b0);
        do_instr(i_type(6'h08, 5'd0, 5'd2, 16'hFFFD), 0, 1'b0);
        do_instr(r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0, 1'b0);
        chk("lat_3instr", 64'(cyc - t0), 64'd12);
        obs_sel = 5'd3; #1;
        chk("r3_lit", 64'(obs_data), 64'd2);
        chk("model_r3", 64'(m_rf[3]), 64'd2);
        chk("ret_lit", 64'(retired_o), 64'd3);
        chk("pc_lit", 64'(pc_o), 64'd3);

        // lui / slti / sll
        do_instr(i_type(6'h0F, 5'd0, 5'd4, 16'h8000), 0, 1'b0);
        do_instr(i_type(6'h0A, 5'd4, 5'd5, 16'h0000), 0, 1'b0);
        do_instr(r_type(5'd0, 5'd5, 5'd6, 5'd4, 6'h00), 0, 1'b0);
        obs_sel = 5'd4; #1; chk("r4_lit", 64'(obs_data), 64'h8000_0000);
        obs_sel = 5'd5; #1; chk("r5_lit", 64'(obs_data), 64'd1);
        obs_sel = 5'd6; #1; chk("r6_lit", 64'(obs_data), 64'h10);
        chk("model_r6", 64'(m_rf[6]), 64'h10);

        // five stall cycles in FETCH
        t0 = cyc;
        do_instr(i_type(6'h08, 5'd0, 5'd7, 16'h0123), 5, 1'b0);
        chk("lat_stall", 64'(cyc - t0), 64'd9);
        obs_sel = 5'd7; #1; chk("r7_lit", 64'(obs_data), 64'h123);

        // unsupported opcode, then a write to r0
        do_instr(32'hFC00_0000, 0, 1'b0);
        do_instr(i_type(6'h08, 5'd0, 5'd0, 16'd7), 0, 1'b0);
        chk("ill_lit", 64'(illegal_o), 64'd1);
        chk("ret9_lit", 64'(retired_o), 64'd9);
        obs_sel = 5'd0; #1; chk("r0_lit", 64'(obs_data), 64'd0);

        // reset in EXECUTE of add $1,$1,$1 with r1=9
        do_instr(i_type(6'h08, 5'd0, 5'd1, 16'd9), 0, 1'b0);
        imem_valid = 1'b1; imem_rdata = r_type(5'd1, 5'd1, 5'd1, 5'd0, 6'h20);
        @(posedge clk); #1;
        exp_state = 3'd2; exp_req = 1'b0; imem_valid = 1'b0;
        @(posedge clk); #1;
        exp_state = 3'd3;
        #10;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_pc", 64'(pc_o), 64'd0);
        obs_sel = 5'd1; #1; chk("rst_r1", 64'(obs_data), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_state = 3'd1; exp_req = 1'b1;
        chk("refetch_addr", 64'(imem_addr), 64'd0);

        // random stream up to the last PC, then halt while retiring it
        while (m_pc != 8'hFF) do_instr(rand_instr(), int'($urandom_range(0, 2)), 1'b0);
        do_instr(rand_instr(), 0, 1'b1);
        chk("halt_state", 64'(state_o), 64'd5);
        chk("wrap_pc", 64'(pc_o), 64'd0);
        for (int i = 0; i < 10; i++) begin
            imem_valid = 1'($urandom); imem_rdata = $urandom; halt_i = 1'($urandom);
            @(posedge clk); #1;
        end
        sweep();

        // halt requested while leaving IDLE
        halt_i = 1'b1;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_state = 3'd5;
        for (int i = 0; i < 5; i++) begin
            imem_valid = 1'($urandom); halt_i = 1'($urandom);
            @(posedge clk); #1;
        end
        chk("idle_halt", 64'(state_o), 64'd5);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_ri_multicycle.md
CPU_RI_MULTICYCLE -- requirements
Module: cpu_ri_multicycle

Interface
REQ-001 Parameter DATA_W, default 32: datapath and register width; legal range 16..64.
REQ-002 Parameter PC_W, default 8: instruction-address width; PC is word-addressed.
REQ-003 Parameter RET_W, default 16: retired-instruction counter width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1  fetch request, high only in state FETCH.
REQ-007 imem_addr  out  PC_W  fetch address, equal to PC.
REQ-008 imem_valid  in  1  instruction word present on imem_rdata this cycle.
REQ-009 imem_rdata  in  32  instruction word, MIPS R/I encoding.
REQ-010 halt_i  in  1  request to stop before the next fetch.
REQ-011 obs_sel  in  5  register index for the observation port.
REQ-012 obs_data  out  DATA_W  combinational read of register obs_sel.
REQ-013 pc_o  out  PC_W  current PC.
REQ-014 state_o  out  3  FSM state code.
REQ-015 illegal_o  out  1  sticky flag, set by any unsupported instruction.
REQ-016 retired_o  out  RET_W  count of instructions completed in WRITEBACK.

Function
REQ-017 The FSM SHALL use states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4 and HALTED=5.
REQ-018 IDLE SHALL move to FETCH one cycle after reset release, or to HALTED if halt_i is high.
REQ-019 FETCH SHALL hold imem_req high and stay in FETCH until imem_valid is high, then latch imem_rdata into IR and go to DECODE.
REQ-020 DECODE SHALL read rs and rt into operand registers A and B, form the immediate, and go to EXECUTE.
REQ-021 EXECUTE SHALL compute the result into ALUOUT and go to WRITEBACK.
REQ-022 WRITEBACK SHALL write ALUOUT to the destination, set PC to PC+1 (mod 2^PC_W), increment retired_o (wrapping), and go to FETCH, or to HALTED if halt_i is high.
REQ-023 Best-case instruction latency SHALL be 4 cycles: FETCH with imem_valid already high, then DECODE, EXECUTE, WRITEBACK.
REQ-024 R-type instructions (opcode 0) SHALL be supported with these funct codes:
  - add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27: destination rd.
  - slt 0x2A (signed compare): destination rd.
  - sll 0x00 (shift by shamt): destination rd.
REQ-025 I-type instructions SHALL be supported with these opcodes, destination rt:
  - addi 0x08, slti 0x0A: immediate sign-extended to DATA_W.
  - andi 0x0C, ori 0x0D, xori 0x0E: immediate zero-extended.
  - lui 0x0F: imm<<16, truncated to DATA_W.
REQ-026 Add and sub SHALL wrap modulo 2^DATA_W with no overflow trap.
REQ-027 slt and slti SHALL write 1 or 0, zero-extended to DATA_W.
REQ-028 Register 0 SHALL always read zero, and writes to it SHALL be discarded.
REQ-029 An unsupported opcode or funct SHALL set illegal_o, perform no register write, and still advance PC and retired_o.
REQ-030 HALTED SHALL hold all state until reset; halt_i SHALL be sampled only in IDLE and WRITEBACK.
REQ-031 imem_valid outside FETCH SHALL be ignored.
REQ-032 If WRITEBACK writes register obs_sel, obs_data SHALL show the new value from the cycle after that edge.

Reset
REQ-033 Asserting rst_n low SHALL immediately, at any point including mid-instruction, set:
  - state IDLE, PC 0, IR 0, A, B and ALUOUT 0;
  - all registers 0, illegal_o 0, retired_o 0, imem_req 0.
REQ-034 An instruction interrupted by reset SHALL leave no architectural effect.

Verification
REQ-035 Scenario: addi $1,$0,5 then addi $2,$0,-3 then add $3,$1,$2 (imem_valid always high) -> obs_data for r3 reads 2, retired_o=3, pc_o=3, after 12 cycles past IDLE.
REQ-036 Scenario: lui $4,0x8000 then slti $5,$4,0 then sll $6,$5,4, with DATA_W=32 -> r4=0x80000000, r5=1, r6=0x10.
REQ-037 Scenario: imem_valid held low 5 cycles in FETCH -> imem_req stays high, state_o=1 throughout, and the instruction completes 5 cycles late with the correct result.
REQ-038 Scenario: opcode 0x3F, then addi $0,$0,7 -> illegal_o=1 and stays 1, r0=0, retired_o=2.
REQ-039 Scenario: rst_n pulsed low during EXECUTE of add $1,$1,$1 with r1=9 -> r1=0, pc_o=0, state_o=0 immediately, and fetch restarts at address 0.
REQ-040 Scenario: halt_i high during WRITEBACK; also PC=2^PC_W-1 retiring -> state_o=5 and stays there; pc_o wraps to 0 with no further fetch.
